// File: rtl/load_store_unit_pkg.sv
// Shared encodings, FSM state type and alignment helpers for the load/store unit.
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Size 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            default:   bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] offset);
        logic [1:0] aligned;
        case (size)
            SIZE_BYTE: aligned = offset;
            SIZE_HALF: aligned = {offset[1], 1'b0};
            default:   aligned = 2'b00;
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus word-indexed memory port.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  reqValid;
    logic                  reqReady;
    logic                  reqWrite;
    logic [1:0]            reqSize;
    logic                  reqSigned;
    logic [ADDR_WIDTH-1:0] reqAddr;
    logic [DATA_WIDTH-1:0] reqWdata;
    logic                  respValid;
    logic                  respReady;
    logic [DATA_WIDTH-1:0] respData;
    logic                  respError;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic                  memReadEnable;
    logic                  memWriteEnable;
    logic [DATA_WIDTH-1:0] memDataIn;
    logic [DATA_WIDTH-1:0] memDataOut;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWdata, respReady, memDataOut,
        output reqReady, respValid, respData, respError,
               memAddress, memReadEnable, memWriteEnable, memDataIn
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWdata, respReady, memDataOut,
        input  reqReady, respValid, respData, respError,
               memAddress, memReadEnable, memWriteEnable, memDataIn
    );
endinterface

// File: rtl/load_store_unit_mem_lane_align.sv
// Little-endian lane extraction with sign/zero extension, and sub-word merge for RMW stores.
module mem_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Load path: pick the addressed lane and extend it to a full word.
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        o_load_data = 32'h0000_0000;
        case (i_offset)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            2'b11:   w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_offset[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
        case (i_size)
            SIZE_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            default:   o_load_data = i_rdata;
        endcase
    end

    // Store path: replace only the addressed lane of the old word.
    always_comb begin
        o_merged = i_rdata;
        case (i_size)
            SIZE_BYTE: begin
                case (i_offset)
                    2'b00:   o_merged = {i_rdata[31:8], i_wdata[7:0]};
                    2'b01:   o_merged = {i_rdata[31:16], i_wdata[7:0], i_rdata[7:0]};
                    2'b10:   o_merged = {i_rdata[31:24], i_wdata[7:0], i_rdata[15:0]};
                    2'b11:   o_merged = {i_wdata[7:0], i_rdata[23:0]};
                    default: o_merged = i_rdata;
                endcase
            end
            SIZE_HALF: begin
                if (i_offset[1]) begin
                    o_merged = {i_wdata[15:0], i_rdata[15:0]};
                end else begin
                    o_merged = {i_rdata[31:16], i_wdata[15:0]};
                end
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator; sub-word stores use read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter bit MISALIGN_ERROR = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    load_store_unit_if.slave bus
);

    lsu_state_e            r_state;
    lsu_state_e            w_next_state;

    logic                  r_write;
    logic                  r_signed;
    logic [1:0]            r_size;
    logic [1:0]            r_offset;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_error;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_re;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_din;

    logic                  w_req_ready_nxt;
    logic                  w_resp_valid_nxt;
    logic [DATA_WIDTH-1:0] w_resp_data_nxt;
    logic                  w_resp_error_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic                  w_mem_re_nxt;
    logic                  w_mem_we_nxt;
    logic [DATA_WIDTH-1:0] w_mem_din_nxt;

    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_word_size;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_accept     = (r_state == ST_IDLE) && r_req_ready && bus.reqValid;
    assign w_misaligned = MISALIGN_ERROR && is_misaligned(bus.reqSize, bus.reqAddr[1:0]);
    assign w_word_size  = bus.reqSize[1];

    mem_lane_align u_align (
        .i_rdata    (bus.memDataOut),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_signed   (r_signed),
        .i_wdata    (r_wdata),
        .o_load_data(w_load_data),
        .o_merged   (w_merged)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture on the accept edge; offset is pre-aligned when misalignment is tolerated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= SIZE_BYTE;
            r_offset <= 2'b00;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_write  <= bus.reqWrite;
            r_signed <= bus.reqSigned;
            r_size   <= bus.reqSize;
            r_offset <= align_offset(bus.reqSize, bus.reqAddr[1:0]);
            r_wdata  <= bus.reqWdata;
        end else begin
            r_write  <= r_write;
            r_signed <= r_signed;
            r_size   <= r_size;
            r_offset <= r_offset;
            r_wdata  <= r_wdata;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_accept) begin
                    w_next_state = ST_IDLE;
                end else if (w_misaligned) begin
                    w_next_state = ST_RESP;
                end else if (bus.reqWrite && w_word_size) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                if (r_write) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            ST_WRITE: w_next_state = ST_RESP;
            ST_RESP: begin
                if (bus.respReady) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so every output is a flop that is stable per state.
    always_comb begin
        w_req_ready_nxt  = (w_next_state == ST_IDLE);
        w_resp_valid_nxt = (w_next_state == ST_RESP);
        w_mem_re_nxt     = (w_next_state == ST_READ);
        w_mem_we_nxt     = (w_next_state == ST_WRITE);
        w_resp_data_nxt  = '0;
        w_resp_error_nxt = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_din_nxt    = r_mem_din;
        if (w_next_state == ST_RESP) begin
            case (r_state)
                ST_IDLE: begin
                    w_resp_data_nxt  = '0;
                    w_resp_error_nxt = 1'b1;
                end
                ST_READ: begin
                    w_resp_data_nxt  = r_write ? '0 : w_load_data;
                    w_resp_error_nxt = 1'b0;
                end
                ST_RESP: begin
                    w_resp_data_nxt  = r_resp_data;
                    w_resp_error_nxt = r_resp_error;
                end
                default: begin
                    w_resp_data_nxt  = '0;
                    w_resp_error_nxt = 1'b0;
                end
            endcase
        end else begin
            w_resp_data_nxt  = '0;
            w_resp_error_nxt = 1'b0;
        end
        if (w_accept) begin
            w_mem_addr_nxt = {2'b00, bus.reqAddr[ADDR_WIDTH-1:2]};
        end else begin
            w_mem_addr_nxt = r_mem_addr;
        end
        if (w_next_state == ST_WRITE) begin
            w_mem_din_nxt = (r_state == ST_IDLE) ? bus.reqWdata : w_merged;
        end else begin
            w_mem_din_nxt = r_mem_din;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_din    <= '0;
        end else begin
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_error <= w_resp_error_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_re     <= w_mem_re_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_din    <= w_mem_din_nxt;
        end
    end

    assign bus.reqReady       = r_req_ready;
    assign bus.respValid      = r_resp_valid;
    assign bus.respData       = r_resp_data;
    assign bus.respError      = r_resp_error;
    assign bus.memAddress     = r_mem_addr;
    assign bus.memReadEnable  = r_mem_re;
    assign bus.memWriteEnable = r_mem_we;
    assign bus.memDataIn      = r_mem_din;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-indexed memory model.
module tb_load_store_unit;

    logic clk;
    logic reset_n;

    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    load_store_unit #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .MISALIGN_ERROR(1'b1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [31:0] mem [0:15];
    logic        bd_we;
    logic [3:0]  bd_addr;
    logic [31:0] bd_data;
    int          re_cnt = 0;
    int          we_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.memDataOut = mem[bus.memAddress[3:0]];

    always @(posedge clk) begin
        if (bus.memWriteEnable) begin
            mem[bus.memAddress[3:0]] <= bus.memDataIn;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
        if (bus.memReadEnable) re_cnt <= re_cnt + 1;
        if (bus.memWriteEnable) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_addr = idx;
        bd_data = data;
        tick();
        bd_we   = 1'b0;
    endtask

    // Leaves the caller 1 time unit after the accept edge.
    task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < 20 && !bus.reqReady; i++) tick();
        check("req_ready_wait", 32'(bus.reqReady), 32'd1);
        bus.reqValid  = 1'b1;
        bus.reqWrite  = wr;
        bus.reqSize   = size;
        bus.reqSigned = sgn;
        bus.reqAddr   = addr;
        bus.reqWdata  = wdata;
        tick();
        bus.reqValid  = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] exp);
        do_req(1'b0, size, sgn, addr, 32'h0000_0000);
        check({tag, "_re"}, 32'(bus.memReadEnable), 32'd1);
        check({tag, "_we"}, 32'(bus.memWriteEnable), 32'd0);
        check({tag, "_addr"}, bus.memAddress, {2'b00, addr[31:2]});
        tick();
        check({tag, "_valid"}, 32'(bus.respValid), 32'd1);
        check({tag, "_data"}, bus.respData, exp);
        check({tag, "_err"}, 32'(bus.respError), 32'd0);
        tick();
    endtask

    initial begin
        int re_snap;
        int we_snap;
        reset_n       = 1'b0;
        bd_we         = 1'b0;
        bd_addr       = 4'd0;
        bd_data       = 32'd0;
        bus.reqValid  = 1'b0;
        bus.reqWrite  = 1'b0;
        bus.reqSize   = 2'b00;
        bus.reqSigned = 1'b0;
        bus.reqAddr   = 32'd0;
        bus.reqWdata  = 32'd0;
        bus.respReady = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;

        // Reset state
        tick();
        check("rst_req_ready", 32'(bus.reqReady), 32'd0);
        check("rst_resp_valid", 32'(bus.respValid), 32'd0);
        check("rst_resp_data", bus.respData, 32'd0);
        check("rst_mem_addr", bus.memAddress, 32'd0);
        check("rst_mem_re", 32'(bus.memReadEnable), 32'd0);
        check("rst_mem_we", 32'(bus.memWriteEnable), 32'd0);
        check("rst_mem_din", bus.memDataIn, 32'd0);
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(bus.reqReady), 32'd1);

        // Word store then load back
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        check("wst_we", 32'(bus.memWriteEnable), 32'd1);
        check("wst_re", 32'(bus.memReadEnable), 32'd0);
        check("wst_addr", bus.memAddress, 32'd4);
        check("wst_din", bus.memDataIn, 32'hDEAD_BEEF);
        check("wst_ready", 32'(bus.reqReady), 32'd0);
        tick();
        check("wst_valid", 32'(bus.respValid), 32'd1);
        check("wst_data", bus.respData, 32'd0);
        check("wst_we_off", 32'(bus.memWriteEnable), 32'd0);
        tick();
        check("wst_idle_ready", 32'(bus.reqReady), 32'd1);
        check("wst_idle_valid", 32'(bus.respValid), 32'd0);
        check("wst_mem", mem[4], 32'hDEAD_BEEF);
        run_load("wld", 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);

        // Sub-word loads with sign/zero extension
        preload(4'd4, 32'h80FF_7F01);
        run_load("lb13s", 2'b00, 1'b1, 32'h0000_0013, 32'hFFFF_FF80);
        run_load("lb12u", 2'b00, 1'b0, 32'h0000_0012, 32'h0000_00FF);
        run_load("lb10s", 2'b00, 1'b1, 32'h0000_0010, 32'h0000_0001);
        run_load("lb11s", 2'b00, 1'b1, 32'h0000_0011, 32'h0000_007F);
        run_load("lh12s", 2'b01, 1'b1, 32'h0000_0012, 32'hFFFF_80FF);
        run_load("lh10u", 2'b01, 1'b0, 32'h0000_0010, 32'h0000_7F01);
        run_load("lw11sz", 2'b11, 1'b1, 32'h0000_0010, 32'h80FF_7F01);

        // Half store read-modify-write
        preload(4'd4, 32'h1122_3344);
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hAAAA_5555);
        check("hst_rd_re", 32'(bus.memReadEnable), 32'd1);
        check("hst_rd_we", 32'(bus.memWriteEnable), 32'd0);
        check("hst_rd_addr", bus.memAddress, 32'd4);
        tick();
        check("hst_wr_we", 32'(bus.memWriteEnable), 32'd1);
        check("hst_wr_re", 32'(bus.memReadEnable), 32'd0);
        check("hst_wr_addr", bus.memAddress, 32'd4);
        check("hst_wr_din", bus.memDataIn, 32'h5555_3344);
        check("hst_wr_valid", 32'(bus.respValid), 32'd0);
        tick();
        check("hst_valid", 32'(bus.respValid), 32'd1);
        check("hst_data", bus.respData, 32'd0);
        tick();
        check("hst_mem", mem[4], 32'h5555_3344);

        // Byte store into lane 1
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00AB);
        tick();
        check("bst_din", bus.memDataIn, 32'h5555_AB44);
        tick();
        tick();
        check("bst_mem", mem[4], 32'h5555_AB44);

        // Misaligned word load and half store: error, no strobes
        re_snap = re_cnt;
        we_snap = we_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h0000_0000);
        check("mis_valid", 32'(bus.respValid), 32'd1);
        check("mis_err", 32'(bus.respError), 32'd1);
        check("mis_data", bus.respData, 32'd0);
        check("mis_re", 32'(bus.memReadEnable), 32'd0);
        check("mis_we", 32'(bus.memWriteEnable), 32'd0);
        tick();
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h0000_1234);
        check("mis_h_err", 32'(bus.respError), 32'd1);
        tick();
        check("mis_re_cnt", 32'(re_cnt - re_snap), 32'd0);
        check("mis_we_cnt", 32'(we_cnt - we_snap), 32'd0);
        check("mis_mem", mem[4], 32'h5555_AB44);

        // Backpressure on the response
        bus.respReady = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000);
        tick();
        re_snap = re_cnt;
        we_snap = we_cnt;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.respValid), 32'd1);
            check("bp_data", bus.respData, 32'h5555_AB44);
            check("bp_ready", 32'(bus.reqReady), 32'd0);
            tick();
        end
        check("bp_re_cnt", 32'(re_cnt - re_snap), 32'd0);
        check("bp_we_cnt", 32'(we_cnt - we_snap), 32'd0);
        bus.respReady = 1'b1;
        tick();
        check("bp_release_valid", 32'(bus.respValid), 32'd0);
        check("bp_release_ready", 32'(bus.reqReady), 32'd1);

        // Reset during the READ of a byte store
        preload(4'd5, 32'hCAFE_F00D);
        we_snap = we_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0014, 32'h0000_0012);
        check("mr_rd_re", 32'(bus.memReadEnable), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_re", 32'(bus.memReadEnable), 32'd0);
        check("mr_we", 32'(bus.memWriteEnable), 32'd0);
        check("mr_valid", 32'(bus.respValid), 32'd0);
        check("mr_ready", 32'(bus.reqReady), 32'd0);
        check("mr_addr", bus.memAddress, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("mr_post_ready", 32'(bus.reqReady), 32'd1);
        check("mr_mem", mem[5], 32'hCAFE_F00D);
        check("mr_we_cnt", 32'(we_cnt - we_snap), 32'd0);
        run_load("mr_load", 2'b00, 1'b0, 32'h0000_0017, 32'h0000_00CA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
